uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//   16x-oversampled UART receive engine; sits directly downstream of the baud rate generator.
//   Consumes the one-clk BCLK enable pulse, synchronises the serial line, detects and validates the start bit,
//   samples data/parity/stop at mid-bit and presents one parallel byte per frame with error flags.
//   Output feeds the RX FIFO / host interface.
// PARAMETERS
//   DATA_BITS   8   data bits per frame (5..8), LSB first
//   PARITY_EN   0   1 = parity bit present after data
//   PARITY_ODD  0   1 = odd parity, 0 = even (ignored when PARITY_EN=0)
//   OVERSAMPLE  16  BCLK ticks per bit; must match the generator's x16 divisor
// PORTS
//   clk         in   1          system clock (same clock as baud generator)
//   arst_n      in   1          reset: one clock; reset is synchronous and active-low
//   BCLK        in   1          oversample enable, 1 clk wide, OVERSAMPLE per bit period
//   rx_in       in   1          asynchronous serial line, idle high
//   rx_data     out  DATA_BITS  received word; held until next rx_valid
//   rx_valid    out  1          1-clk pulse: rx_data/parity_err/frame_err valid
//   parity_err  out  1          parity mismatch for this frame (qualified by rx_valid)
//   frame_err   out  1          stop bit sampled 0 (qualified by rx_valid)
//   rx_busy     out  1          high in any state other than IDLE
// BEHAVIOUR
//   - Reset (arst_n=0 at posedge clk): state=IDLE, tick_cnt=0, bit_cnt=0, shift reg=0, sync flops=1,
//     rx_data=0, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0. Reset mid-frame aborts the frame, no rx_valid.
//   - rx_in passes a 2-flop synchroniser (reset to 1); FSM uses only the synchronised value rx_s.
//   - All FSM counting advances only on clk edges where BCLK=1; no BCLK -> state frozen (outputs hold).
//   - tick_cnt width = $clog2(OVERSAMPLE); cleared on every state change.
//   - IDLE: rx_s=0 (sampled any clk, BCLK not required) -> START, tick_cnt=0.
//   - START: on BCLK count; at tick_cnt==OVERSAMPLE/2-1 (mid start bit): rx_s=0 -> DATA, tick_cnt=0, bit_cnt=0;
//     rx_s=1 -> false start (glitch), back to IDLE, no output.
//   - DATA: at tick_cnt==OVERSAMPLE-1 sample rx_s into shift reg MSB, shift right (LSB first);
//     after bit_cnt==DATA_BITS-1 -> PARITY if PARITY_EN else STOP.
//   - PARITY: at tick_cnt==OVERSAMPLE-1 store parity_bad = (^data ^ rx_s ^ PARITY_ODD); -> STOP.
//   - STOP: at tick_cnt==OVERSAMPLE-1 (mid stop bit): rx_data<=shift reg, rx_valid<=1 next clk,
//     parity_err<=parity_bad (0 if !PARITY_EN), frame_err<=~rx_s.
//     rx_s=1 -> IDLE (leaves half a stop bit margin: back-to-back frames accepted);
//     rx_s=0 -> BREAK.
//   - BREAK: wait for rx_s=1 -> IDLE; no further rx_valid while line held low.
//   - Latency: rx_valid asserted the clk after the BCLK edge that samples the stop bit; exactly 1 clk wide.
//   - rx_valid is issued even on errors; consumer decides to drop. Error flags hold until next rx_valid.
//   - rx_in change coincident with BCLK: synchroniser delay (2 clk) applies; sample uses rx_s at that edge.
// STRUCTURE
//   - uart_pkg: rx state enum {IDLE,START,DATA,PARITY,STOP,BREAK}, OVERSAMPLE default constant (16).
//   - Sub-module uart_rx_sync: 2-flop synchroniser, reset value 1, parameterless.
//   - FSM + counters + shift register + output regs in this module; no combinational outputs.
// TESTING  (bench: clk 10 MHz, baud generator 9600 -> BCLK every 65 clk, 8N1 unless stated)
//   - Send 0xA5 with valid stop -> rx_data=0xA5, rx_valid 1 clk, parity_err=0, frame_err=0, rx_busy low after.
//   - rx_in low for 4 BCLK then high (glitch) -> returns to IDLE, no rx_valid, rx_data unchanged.
//   - Send 0x3C with stop=0, line held low 3 bit times -> rx_valid with frame_err=1; no second rx_valid
//     until line high; next frame 0x55 received clean with frame_err=0.
//   - PARITY_EN=1 even: send 0x07 with parity bit 0 -> parity_err=1; with parity 1 -> parity_err=0.
//   - Back-to-back 0x00 then 0xFF, no idle gap -> two rx_valid pulses, 0x00 then 0xFF, no errors.
//   - Assert arst_n=0 for 1 clk during DATA bit 4 -> all outputs at reset values, no rx_valid, next frame 0x81 ok.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path:
// receiver state encoding and default oversample ratio.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both flops reset to the idle (mark) level.
module uart_rx_sync (
    input  logic clk,
    input  logic arst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Double-register the line; reset to idle-high so no false start.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampled UART receive engine: start validation, mid-bit
// sampling of data/parity/stop, registered byte and error flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 BCLK,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);
    localparam logic          PAR_ON   = (PARITY_EN != 0);

    rx_state_e r_state;
    rx_state_e w_state_nxt;

    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;

    logic w_rx_s;
    logic w_tick_inc;
    logic w_shift;
    logic w_par_ld;
    logic w_done;
    logic w_enter_data;
    logic w_tick_clr;

    uart_rx_sync u_sync (
        .clk    (clk),
        .arst_n (arst_n),
        .i_d    (rx_in),
        .o_q    (w_rx_s)
    );

    // Next state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_inc  = 1'b0;
        w_shift     = 1'b0;
        w_par_ld    = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (BCLK) begin
                    if (r_tick == TICK_MID) begin
                        w_state_nxt = w_rx_s ? IDLE : DATA;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (BCLK) begin
                    if (r_tick == TICK_END) begin
                        w_shift = 1'b1;
                        if (r_bit == BIT_LAST) begin
                            w_state_nxt = PAR_ON ? PARITY : STOP;
                        end
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (BCLK) begin
                    if (r_tick == TICK_END) begin
                        w_par_ld    = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                if (BCLK) begin
                    if (r_tick == TICK_END) begin
                        w_done      = 1'b1;
                        w_state_nxt = w_rx_s ? IDLE : BREAK;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
            end
            BREAK: begin
                if (BCLK && w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_enter_data = (r_state == START) && (w_state_nxt == DATA);
    assign w_tick_clr   = (w_state_nxt != r_state) || w_shift;

    // State register.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Oversample tick and bit counters.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_tick <= '0;
            r_bit  <= '0;
        end else begin
            if (w_tick_clr) begin
                r_tick <= '0;
            end else if (w_tick_inc) begin
                r_tick <= r_tick + TW'(1);
            end
            if (w_enter_data) begin
                r_bit <= '0;
            end else if (w_shift) begin
                r_bit <= r_bit + BW'(1);
            end
        end
    end

    // LSB-first shift register and parity check.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            if (w_shift) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            end
            if (w_par_ld) begin
                r_par_bad <= (^r_shift) ^ w_rx_s ^ PAR_ODD;
            end
        end
    end

    // Registered outputs; valid pulses once per sampled stop bit.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            rx_valid <= w_done;
            rx_busy  <= (w_state_nxt != IDLE);
            if (w_done) begin
                rx_data    <= r_shift;
                parity_err <= PAR_ON & r_par_bad;
                frame_err  <= ~w_rx_s;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: 8N1 instance plus an
// even-parity instance sharing clock, BCLK and reset.
module tb_uart_rx_core;

    localparam int BDIV   = 16;
    localparam int BITCLK = 16 * BDIV;

    logic       clk;
    logic       arst_n;
    logic       BCLK;
    logic       rx;
    logic       rxp;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;
    logic [7:0] rx_data_p;
    logic       rx_valid_p;
    logic       parity_err_p;
    logic       frame_err_p;
    logic       rx_busy_p;

    int checks;
    int failures;
    int vcnt;
    int vcnt_p;
    int wide;
    logic prev_v;
    logic prev_vp;

    uart_rx_core #(
        .DATA_BITS  (8),
        .PARITY_EN  (0),
        .PARITY_ODD (0),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .BCLK       (BCLK),
        .rx_in      (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    uart_rx_core #(
        .DATA_BITS  (8),
        .PARITY_EN  (1),
        .PARITY_ODD (0),
        .OVERSAMPLE (16)
    ) dutp (
        .clk        (clk),
        .arst_n     (arst_n),
        .BCLK       (BCLK),
        .rx_in      (rxp),
        .rx_data    (rx_data_p),
        .rx_valid   (rx_valid_p),
        .parity_err (parity_err_p),
        .frame_err  (frame_err_p),
        .rx_busy    (rx_busy_p)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    initial begin
        BCLK = 1'b0;
        forever begin
            repeat (BDIV - 1) @(negedge clk);
            BCLK = 1'b1;
            @(negedge clk);
            BCLK = 1'b0;
        end
    end

    initial begin
        vcnt    = 0;
        vcnt_p  = 0;
        wide    = 0;
        prev_v  = 1'b0;
        prev_vp = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) vcnt++;
            if (rx_valid_p === 1'b1) vcnt_p++;
            if (rx_valid === 1'b1 && prev_v === 1'b1) wide++;
            if (rx_valid_p === 1'b1 && prev_vp === 1'b1) wide++;
            prev_v  = rx_valid;
            prev_vp = rx_valid_p;
        end
    end

    task automatic drive_bit(input logic v, input bit pl);
        if (pl) rxp = v;
        else rx = v;
        repeat (BITCLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input bit pl, input bit has_par,
                              input logic par);
        drive_bit(1'b0, pl);
        for (int i = 0; i < 8; i++) drive_bit(d[i], pl);
        if (has_par) drive_bit(par, pl);
        drive_bit(stop, pl);
    endtask

    task automatic test_reset;
        arst_n = 1'b0;
        rx     = 1'b1;
        rxp    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", rx_data);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", rx_valid);
        end
        checks++;
        if (parity_err !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_errs got=%b%b exp=00", parity_err, frame_err);
        end
        checks++;
        if (rx_busy !== 1'b0 || rx_busy_p !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b%b exp=00", rx_busy, rx_busy_p);
        end
        arst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (rx_busy !== 1'b0 || vcnt != 0) begin
            failures++;
            $display("FAIL reset_idle busy=%b vcnt=%0d exp 0/0", rx_busy, vcnt);
        end
    endtask

    task automatic test_a5;
        int v0;
        v0 = vcnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (BITCLK) @(negedge clk);
        checks++;
        if (vcnt != v0 + 1) begin
            failures++;
            $display("FAIL a5_count got=%0d exp=%0d", vcnt, v0 + 1);
        end
        checks++;
        if (rx_data !== 8'hA5) begin
            failures++;
            $display("FAIL a5_data got=%h exp=a5", rx_data);
        end
        checks++;
        if (parity_err !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL a5_errs got=%b%b exp=00", parity_err, frame_err);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL a5_busy got=%b exp=0", rx_busy);
        end
        checks++;
        if (wide != 0) begin
            failures++;
            $display("FAIL a5_pulse_width wide=%0d exp=0", wide);
        end
    endtask

    task automatic test_glitch;
        int v0;
        v0 = vcnt;
        rx = 1'b0;
        repeat (4 * BDIV) @(negedge clk);
        checks++;
        if (rx_busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_start got=%b exp=1", rx_busy);
        end
        rx = 1'b1;
        repeat (2 * BITCLK) @(negedge clk);
        checks++;
        if (vcnt != v0) begin
            failures++;
            $display("FAIL glitch_count got=%0d exp=%0d", vcnt, v0);
        end
        checks++;
        if (rx_data !== 8'hA5) begin
            failures++;
            $display("FAIL glitch_data got=%h exp=a5", rx_data);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy_end got=%b exp=0", rx_busy);
        end
    endtask

    task automatic test_frame_err;
        int v0;
        v0 = vcnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (vcnt != v0 + 1 || rx_data !== 8'h3C) begin
            failures++;
            $display("FAIL ferr_frame cnt=%0d data=%h exp %0d/3c",
                     vcnt, rx_data, v0 + 1);
        end
        checks++;
        if (frame_err !== 1'b1 || parity_err !== 1'b0) begin
            failures++;
            $display("FAIL ferr_flags got=%b%b exp=01", parity_err, frame_err);
        end
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        checks++;
        if (vcnt != v0 + 1) begin
            failures++;
            $display("FAIL ferr_break_count got=%0d exp=%0d", vcnt, v0 + 1);
        end
        checks++;
        if (rx_busy !== 1'b1) begin
            failures++;
            $display("FAIL ferr_break_busy got=%b exp=1", rx_busy);
        end
        rx = 1'b1;
        repeat (BITCLK) @(negedge clk);
        checks++;
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL ferr_idle_busy got=%b exp=0", rx_busy);
        end
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (vcnt != v0 + 2 || rx_data !== 8'h55) begin
            failures++;
            $display("FAIL ferr_next cnt=%0d data=%h exp %0d/55",
                     vcnt, rx_data, v0 + 2);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL ferr_next_flag got=%b exp=0", frame_err);
        end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = vcnt;
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (vcnt != v0 + 1 || rx_data !== 8'h00) begin
            failures++;
            $display("FAIL b2b_first cnt=%0d data=%h exp %0d/00",
                     vcnt, rx_data, v0 + 1);
        end
        checks++;
        if (frame_err !== 1'b0 || parity_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first_errs got=%b%b exp=00", parity_err, frame_err);
        end
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (vcnt != v0 + 2 || rx_data !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_second cnt=%0d data=%h exp %0d/ff",
                     vcnt, rx_data, v0 + 2);
        end
        checks++;
        if (frame_err !== 1'b0 || parity_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_errs got=%b%b exp=00", parity_err, frame_err);
        end
        checks++;
        if (wide != 0) begin
            failures++;
            $display("FAIL b2b_pulse_width wide=%0d exp=0", wide);
        end
    endtask

    task automatic test_parity;
        int v0;
        v0 = vcnt_p;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (vcnt_p != v0 + 1 || rx_data_p !== 8'h07) begin
            failures++;
            $display("FAIL par_good_frame cnt=%0d data=%h exp %0d/07",
                     vcnt_p, rx_data_p, v0 + 1);
        end
        checks++;
        if (parity_err_p !== 1'b0 || frame_err_p !== 1'b0) begin
            failures++;
            $display("FAIL par_good_errs got=%b%b exp=00", parity_err_p, frame_err_p);
        end
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (vcnt_p != v0 + 2 || rx_data_p !== 8'h07) begin
            failures++;
            $display("FAIL par_bad_frame cnt=%0d data=%h exp %0d/07",
                     vcnt_p, rx_data_p, v0 + 2);
        end
        checks++;
        if (parity_err_p !== 1'b1 || frame_err_p !== 1'b0) begin
            failures++;
            $display("FAIL par_bad_errs got=%b%b exp=10", parity_err_p, frame_err_p);
        end
        checks++;
        if (rx_busy_p !== 1'b0) begin
            failures++;
            $display("FAIL par_busy got=%b exp=0", rx_busy_p);
        end
    endtask

    task automatic test_reset_mid;
        int v0;
        logic [7:0] d;
        v0 = vcnt;
        d  = 8'h81;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
        rx = d[4];
        repeat (BITCLK / 2) @(negedge clk);
        checks++;
        if (rx_busy !== 1'b1) begin
            failures++;
            $display("FAIL rmid_busy_before got=%b exp=1", rx_busy);
        end
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        rx     = 1'b1;
        checks++;
        if (rx_data !== 8'h00 || rx_data_p !== 8'h00) begin
            failures++;
            $display("FAIL rmid_data got=%h/%h exp=00/00", rx_data, rx_data_p);
        end
        checks++;
        if (rx_valid !== 1'b0 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL rmid_ctl valid=%b busy=%b exp 0/0", rx_valid, rx_busy);
        end
        checks++;
        if (parity_err_p !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL rmid_errs got=%b%b exp=00", parity_err_p, frame_err);
        end
        repeat (2 * BITCLK) @(negedge clk);
        checks++;
        if (vcnt != v0 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL rmid_abort cnt=%0d busy=%b exp %0d/0", vcnt, rx_busy, v0);
        end
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (vcnt != v0 + 1 || rx_data !== 8'h81) begin
            failures++;
            $display("FAIL rmid_next cnt=%0d data=%h exp %0d/81",
                     vcnt, rx_data, v0 + 1);
        end
        checks++;
        if (frame_err !== 1'b0 || wide != 0) begin
            failures++;
            $display("FAIL rmid_next_flags ferr=%b wide=%0d exp 0/0", frame_err, wide);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        arst_n   = 1'b0;
        rx       = 1'b1;
        rxp      = 1'b1;
        @(negedge clk);
        test_reset();
        test_a5();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_parity();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
